// File: rtl/fft_out_framer_pkg.sv
// Shared constants and point-size helpers for the FFT output framer.
// Frames are at most 1024 bins; bin indices are 10 bits wide.
package fft_pkg;

    localparam int MAX_POINT = 1024;
    localparam int IDX_W     = 10;
    localparam int POINT_W   = 11;
    localparam int TAG_W     = IDX_W + 2;

    function automatic logic point_legal(input logic [POINT_W-1:0] p);
        return (p >= 11'd16) && (p <= 11'd1024)
            && ((p & (p - 11'd1)) == '0);
    endfunction

    // Last bin index of a frame; illegal sizes fall back to 1024.
    function automatic logic [IDX_W-1:0] point_last(
        input logic [POINT_W-1:0] p
    );
        logic [POINT_W-1:0] m;
        m = point_legal(p) ? (p - 11'd1) : POINT_W'(MAX_POINT - 1);
        return m[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/fft_out_framer_if.sv
// Sample stream bundle between the FFT reorder stage, the framer and
// the downstream consumer.
interface fft_out_framer_if #(
    parameter int DWIDTH = 32
);
    import fft_pkg::*;

    logic [DWIDTH-1:0]  i_data;
    logic               i_valid;
    logic [POINT_W-1:0] i_point;
    logic               i_ready;
    logic [DWIDTH-1:0]  o_data;
    logic               o_valid;
    logic               o_sof;
    logic               o_eof;
    logic [IDX_W-1:0]   o_index;

    modport master (
        input  i_data, i_valid, i_point, i_ready,
        output o_data, o_valid, o_sof, o_eof, o_index
    );

    modport slave (
        output i_data, i_valid, i_point, i_ready,
        input  o_data, o_valid, o_sof, o_eof, o_index
    );

endinterface

// File: rtl/fft_out_framer_fifo.sv
// First-word-fall-through synchronous FIFO; head word is zero when
// empty so downstream never sees stale data.
module sync_fifo_fwft #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      level;
    logic             do_wr;
    logic             do_rd;

    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = empty ? '0 : mem[rp];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= wr_data;
    end

endmodule

// File: rtl/fft_out_framer.sv
// Tags reordered FFT samples with sof/eof/bin index and buffers them.
// Optional FFT_FRAMER_DROP_CNT_EN adds a saturating dropped-sample count.
module fft_out_framer
    import fft_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    fft_out_framer_if.master      bus,
    input  logic                  i_ovf_clr,
    output logic                  o_overflow,
    output logic                  o_cfg_err
`ifdef FFT_FRAMER_DROP_CNT_EN
    ,
    output logic [15:0]           o_drop_cnt
`endif
);

    localparam int EW = DWIDTH + TAG_W;

    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_cur;
    logic             first;
    logic             at_eof;
    logic             rd;
    logic             wr;
    logic             drop;
    logic             full;
    logic             empty;
    logic             ovf_q;
    logic             cfg_q;
    logic [EW-1:0]    wr_ent;
    logic [EW-1:0]    rd_ent;

    // Frame length is sampled only on bin 0 so mid-frame changes are ignored.
    assign first    = (cnt == '0);
    assign last_cur = first ? point_last(bus.i_point) : last_q;
    assign at_eof   = (cnt == last_cur);

    assign rd   = !empty && bus.i_ready;
    assign wr   = bus.i_valid && (!full || rd);
    assign drop = bus.i_valid && full && !rd;

    assign wr_ent = {first, at_eof, cnt, bus.i_data};

    sync_fifo_fwft #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr),
        .wr_data (wr_ent),
        .rd_en   (rd),
        .rd_data (rd_ent),
        .empty   (empty),
        .full    (full)
    );

    assign bus.o_valid = !empty;
    assign {bus.o_sof, bus.o_eof, bus.o_index, bus.o_data} = rd_ent;

    // Counter advances on dropped samples too, keeping bins aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            last_q <= IDX_W'(MAX_POINT - 1);
            cfg_q  <= 1'b0;
        end else if (bus.i_valid) begin
            cnt <= at_eof ? '0 : cnt + 1'b1;
            if (first) begin
                last_q <= last_cur;
                if (!point_legal(bus.i_point)) cfg_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (i_ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign o_overflow = ovf_q;
    assign o_cfg_err  = cfg_q;

`ifdef FFT_FRAMER_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else if (drop) begin
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end else if (i_ovf_clr) begin
            drop_q <= '0;
        end
    end

    assign o_drop_cnt = drop_q;
`endif

endmodule
